// File: rtl/inst_prefetch_queue_if.sv
// rtl/inst_prefetch_queue_if.sv - pipeline and instruction-memory signals of the prefetch queue
interface inst_prefetch_queue_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              stall;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [DATA_W-1:0] inst_out;
   logic [ADDR_W-1:0] pc_out;
   logic              consume;

   modport master (
      input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, inst_valid, inst_out, pc_out, consume
   );

   modport slave (
      output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, inst_valid, inst_out, pc_out, consume
   );
endinterface

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - credit-limited instruction prefetch queue feeding the IF stage
// Define PFQ_BYPASS_EN to forward a response into IF in the same cycle when the queue is empty.
module inst_prefetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   inst_prefetch_queue_if.master bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CR_W  = PTR_W + 1;
   localparam logic [CR_W-1:0] DEPTH_C = CR_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  outst_q, outst_d, discard_q, discard_d;
   logic [IDX_W-1:0]  tag_wr_q, tag_rd_q;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              req_q, req_d;
   logic              inst_valid_q, inst_valid_d;
   logic [DATA_W-1:0] inst_out_q, inst_out_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [ADDR_W-1:0] tag_q  [DEPTH];

   logic              issue, resp, keep, byp, push, pop, q_empty;
   logic [PTR_W-1:0]  count_d;
   logic [CR_W-1:0]   credit_d;
   logic [ADDR_W-1:0] tag_head;

   assign tag_head = tag_q[tag_rd_q];
   assign q_empty  = (wr_ptr_q == rd_ptr_q);
   assign issue    = req_q & bus.imem_gnt;
   // Responses with nothing outstanding are leftovers from before a reset.
   assign resp     = bus.imem_rvalid & (outst_q != '0);
   assign keep     = resp & (discard_q == '0) & ~bus.redirect;
`ifdef PFQ_BYPASS_EN
   assign byp      = keep & q_empty;
`else
   assign byp      = 1'b0;
`endif
   assign pop      = inst_valid_q & ~bus.stall;
   assign push     = keep & ~(byp & ~bus.stall);

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = fetch_pc_q;
   assign bus.inst_valid = inst_valid_q | byp;
   assign bus.inst_out   = byp ? bus.imem_rdata : inst_out_q;
   assign bus.pc_out     = byp ? tag_head : pc_out_q;
   assign bus.consume    = bus.inst_valid & ~bus.stall;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      outst_d    = outst_q + PTR_W'(issue) - PTR_W'(resp);
      discard_d  = discard_q - PTR_W'(resp && (discard_q != '0));
      fetch_pc_d = issue ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
      state_d    = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   state_d = FETCH;
         DRAIN:   if (discard_d == '0) state_d = FETCH;
         default: state_d = IDLE;
      endcase
      // Everything still in flight, including a grant taken this cycle, becomes stale.
      if (bus.redirect) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         discard_d  = outst_d;
         fetch_pc_d = bus.redirect_pc;
         state_d    = (outst_d != '0) ? DRAIN : FETCH;
      end
      count_d  = wr_ptr_d - rd_ptr_d;
      credit_d = {1'b0, count_d} + {1'b0, outst_d};
      req_d    = (state_d == FETCH) && (credit_d < DEPTH_C);

      inst_valid_d = (wr_ptr_d != rd_ptr_d);
      inst_out_d   = inst_out_q;
      pc_out_d     = pc_out_q;
      if (inst_valid_d) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            inst_out_d = bus.imem_rdata;
            pc_out_d   = tag_head;
         end else begin
            inst_out_d = data_q[rd_ptr_d[IDX_W-1:0]];
            pc_out_d   = pc_q[rd_ptr_d[IDX_W-1:0]];
         end
      end else if (byp) begin
         inst_out_d = bus.imem_rdata;
         pc_out_d   = tag_head;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         outst_q      <= '0;
         discard_q    <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         fetch_pc_q   <= RESET_PC;
         req_q        <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_out_q   <= '0;
         pc_out_q     <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         fetch_pc_q   <= fetch_pc_d;
         req_q        <= req_d;
         inst_valid_q <= inst_valid_d;
         inst_out_q   <= inst_out_d;
         pc_out_q     <= pc_out_d;
         if (issue) tag_wr_q <= tag_wr_q + IDX_W'(1);
         if (resp)  tag_rd_q <= tag_rd_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (issue) tag_q[tag_wr_q] <= fetch_pc_q;
      if (push) begin
         data_q[wr_ptr_q[IDX_W-1:0]] <= bus.imem_rdata;
         pc_q[wr_ptr_q[IDX_W-1:0]]   <= tag_head;
      end
   end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - directed bench for inst_prefetch_queue with an in-order memory model
module tb_inst_prefetch_queue;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   mem_lat  = 1;
   int   cyc;

   inst_prefetch_queue_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   inst_prefetch_queue #(.DEPTH(4), .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int          rem;
   } mreq_t;
   mreq_t mq[$];

   // Instruction word at address a is a ^ 16'h5A5A; responses come mem_lat cycles after issue.
   always @(posedge clk) begin
      logic        iss;
      logic [15:0] ia;
      iss = bus.imem_req & bus.imem_gnt;
      ia  = bus.imem_addr;
      #1;
      if (bus.imem_rvalid === 1'b1) void'(mq.pop_front());
      if (iss) mq.push_back('{ia, mem_lat});
      foreach (mq[i]) mq[i].rem = mq[i].rem - 1;
      if (mq.size() > 0 && mq[0].rem <= 0) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mq[0].addr ^ 16'h5A5A;
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = 16'h0000;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!bus.inst_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid", 32'(bus.inst_valid), 32'd1);
   endtask

   task automatic expect_seq(input logic [15:0] first, input int n, input int budget, output int c);
      logic [15:0] e;
      int          got;
      e = first;
      got = 0;
      c = 0;
      while (got < n && c < budget) begin
         if (bus.inst_valid) begin
            chk("seq_pc", 32'(bus.pc_out), 32'(e));
            chk("seq_inst", 32'(bus.inst_out), 32'(e ^ 16'h5A5A));
            e = e + 16'd1;
            got++;
         end
         if (got < n) begin
            @(negedge clk);
            c++;
         end
      end
      chk("seq_count", got, n);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_req"},   32'(bus.imem_req),   32'd0);
      chk({tag, "_addr"},  32'(bus.imem_addr),  32'h0000);
      chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
      chk({tag, "_inst"},  32'(bus.inst_out),   32'h0000);
      chk({tag, "_pc"},    32'(bus.pc_out),     32'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      int  n;
      logic seen;
      rst_n = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.stall = 1'b0;
      bus.imem_gnt = 1'b0;
      repeat (2) @(negedge clk);
      reset_vals("por");
      chk("por_consume", 32'(bus.consume), 32'd0);
      rst_n = 1'b1;
      bus.imem_gnt = 1'b1;

      // steady stream, 1-cycle memory
      wait_valid(20, n);
`ifdef PFQ_BYPASS_EN
      chk("t2_fill", n, 2);
`else
      chk("t2_fill", n, 3);
`endif
      expect_seq(16'h0000, 8, 30, cyc);
      chk("t2_rate", cyc, 7);

      // stall: head held, credits run out, nothing lost afterwards
      bus.stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t3_hold_pc", 32'(bus.pc_out), 32'h0007);
      end
      chk("t3_req_off", 32'(bus.imem_req), 32'd0);
      chk("t3_consume", 32'(bus.consume), 32'd0);
      bus.stall = 1'b0;
      expect_seq(16'h0007, 8, 40, cyc);

      // redirect while stalled on a full queue
      bus.stall = 1'b1;
      repeat (6) @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0020;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("t3b_flush", 32'(bus.inst_valid), 32'd0);
      chk("t3b_req", 32'(bus.imem_req), 32'd1);
      chk("t3b_addr", 32'(bus.imem_addr), 32'h0020);
      bus.stall = 1'b0;
      expect_seq(16'h0020, 4, 30, cyc);

      // redirect to 0x0040 with two 3-cycle fetches in flight
      bus.imem_gnt = 1'b0;
      repeat (10) @(negedge clk);
      mem_lat = 3;
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0030;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("t4_req", 32'(bus.imem_req), 32'd1);
      chk("t4_addr", 32'(bus.imem_addr), 32'h0030);
      @(negedge clk);
      chk("t4_addr_hold", 32'(bus.imem_addr), 32'h0030);
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      chk("t4_addr_inc", 32'(bus.imem_addr), 32'h0031);
      @(negedge clk);
      chk("t4_addr_inc2", 32'(bus.imem_addr), 32'h0032);
      bus.imem_gnt = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0040;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.imem_gnt = 1'b1;
      chk("t4_valid", 32'(bus.inst_valid), 32'd0);
      chk("t4_drain_req", 32'(bus.imem_req), 32'd0);
      expect_seq(16'h0040, 3, 40, cyc);

      // redirect in the same cycle as a response and a grant
      bus.imem_gnt = 1'b0;
      repeat (10) @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0050;
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      @(negedge clk);
      chk("t5_req", 32'(bus.imem_req), 32'd1);
      bus.imem_gnt = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0100;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("t5_valid", 32'(bus.inst_valid), 32'd0);
      chk("t5_drain_req", 32'(bus.imem_req), 32'd0);
      expect_seq(16'h0100, 2, 40, cyc);

      // address wrap and response-to-valid latency
      bus.imem_gnt = 1'b0;
      repeat (10) @(negedge clk);
      mem_lat = 1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      @(negedge clk);
      bus.redirect = 1'b0;
      chk("t6_addr", 32'(bus.imem_addr), 32'hFFFF);
      chk("t6_req", 32'(bus.imem_req), 32'd1);
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      chk("t6_wrap", 32'(bus.imem_addr), 32'h0000);
`ifdef PFQ_BYPASS_EN
      chk("t6_byp_valid", 32'(bus.inst_valid), 32'd1);
`else
      chk("t6_reg_valid0", 32'(bus.inst_valid), 32'd0);
      @(negedge clk);
      chk("t6_reg_valid1", 32'(bus.inst_valid), 32'd1);
`endif
      chk("t6_pc", 32'(bus.pc_out), 32'hFFFF);
      chk("t6_inst", 32'(bus.inst_out), 32'hA5A5);

      // reset with two fetches outstanding; their late responses are ignored
      repeat (4) @(negedge clk);
      mem_lat = 3;
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      reset_vals("t1_rst");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | bus.inst_valid;
      end
      chk("t1_late_ignored", 32'(seen), 32'd0);
      chk("t1_req", 32'(bus.imem_req), 32'd1);
      chk("t1_addr", 32'(bus.imem_addr), 32'h0000);
      bus.imem_gnt = 1'b1;
      expect_seq(16'h0000, 3, 40, cyc);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
